bit_serial_alu_ctrl: RTL

BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

---
 rtl/bit_serial_alu_ctrl_if.sv | 25 ++
 rtl/bit_serial_alu_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl_if.sv
// Operand/result bundle between a requester and the bit-serial ALU controller.
interface bit_serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, zero, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, zero, err
    );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU: one operand bit per RUN cycle, LSB first, through a 1-bit slice.
// Result flags are registered only on entry to DONE and held until the next start.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    bit_serial_alu_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             zero_q;
    logic             err_q;

    logic             bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] shift_d;
    logic             last_d;
    logic             arith_d;
    logic             illegal_d;

    // MOV and the two illegal opcodes all pass operand A through.
    function automatic logic slice_bit(input logic [2:0] op, input logic ai,
                                       input logic bi, input logic ci);
        logic r;
        case (op)
            OP_AND:  r = ai & bi;
            OP_OR:   r = ai | bi;
            OP_XOR:  r = ai ^ bi;
            OP_ADD:  r = ai ^ bi ^ ci;
            OP_SUB:  r = ai ^ ~bi ^ ci;
            default: r = ai;
        endcase
        return r;
    endfunction

    function automatic logic slice_carry(input logic [2:0] op, input logic ai,
                                         input logic bi, input logic ci);
        logic bx;
        logic r;
        bx = (op == OP_SUB) ? ~bi : bi;
        if (op == OP_ADD || op == OP_SUB) r = (ai & bx) | (ai & ci) | (bx & ci);
        else                              r = ci;
        return r;
    endfunction

    always_comb begin
        bit_d     = slice_bit(op_q, a_q[0], b_q[0], carry_q);
        carry_d   = slice_carry(op_q, a_q[0], b_q[0], carry_q);
        shift_d   = {bit_d, shift_q[WIDTH-1:1]};
        last_d    = (cnt_q == CW'(WIDTH - 1));
        arith_d   = (op_q == OP_ADD) || (op_q == OP_SUB);
        illegal_d = op_q[2] & op_q[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shift_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        cnt_q   <= '0;
                        carry_q <= (bus.op == OP_SUB);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    shift_q <= shift_d;
                    // Counter reaches WIDTH on the last edge; CW bits hold it without wrapping.
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_d) begin
                        result_q <= shift_d;
                        cout_q   <= arith_d & carry_d;
                        zero_q   <= (shift_d == '0);
                        err_q    <= illegal_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;
endmodule
